// File: rtl/uart_ctrl.sv
// CPU-side register front end for the serial core: DATA/STATUS/CTRL registers,
// byte-wide TX/RX FIFOs, and the we/tx_busy handshake that feeds the core.
module uart_ctrl #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] addr,
    input  logic       wr,
    input  logic       rd,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       irq,
    output logic       uart_en,
    output logic       uart_we,
    output logic [7:0] uart_data_in,
    input  logic       uart_tx_busy,
    input  logic       uart_rx_done,
    input  logic [7:0] uart_data_out
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;

    typedef enum logic [1:0] {
        T_IDLE,
        T_LOAD,
        T_SEND
    } tx_state_t;

    tx_state_t state, state_next;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;

    logic ctrl_en, rx_ie, tx_ie;
    logic tx_ovf, rx_ovf;

    logic tx_empty, tx_full, rx_empty, rx_full;
    logic wr_data, wr_status, wr_ctrl, rd_data, flush;
    logic tx_push, tx_pop, tx_drop, rx_push, rx_pop, rx_drop;
    logic [7:0] status_c;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[AW] != tx_rptr[AW]) && (tx_wptr[AW-1:0] == tx_rptr[AW-1:0]);
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[AW] != rx_rptr[AW]) && (rx_wptr[AW-1:0] == rx_rptr[AW-1:0]);

    assign wr_data   = wr && (addr == A_DATA);
    assign wr_status = wr && (addr == A_STATUS);
    assign wr_ctrl   = wr && (addr == A_CTRL);
    assign rd_data   = rd && (addr == A_DATA);
    assign flush     = wr_ctrl && wdata[3];

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign tx_push = wr_data && (!tx_full || tx_pop);
    assign tx_drop = wr_data && tx_full && !tx_pop;
    assign rx_pop  = rd_data && !rx_empty;
    assign rx_push = uart_rx_done && (!rx_full || rx_pop);
    assign rx_drop = uart_rx_done && rx_full && !rx_pop;

    assign status_c = {1'b0, (state != T_IDLE), tx_ovf, rx_ovf,
                       tx_full, tx_empty, rx_full, rx_empty};

    assign uart_en = ctrl_en;
    assign irq     = (rx_ie && !rx_empty) || (tx_ie && tx_empty);

    // TX FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= T_IDLE;
        else      state <= state_next;
    end

    // TX FSM next state and FIFO pop
    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        case (state)
            T_IDLE: begin
                if (ctrl_en && !tx_empty && !uart_tx_busy) state_next = T_LOAD;
            end
            T_LOAD: begin
                if (!ctrl_en || tx_empty) begin
                    state_next = T_IDLE;
                end else if (uart_tx_busy) begin
                    tx_pop     = 1'b1;
                    state_next = T_SEND;
                end
            end
            T_SEND: begin
                if (!uart_tx_busy) state_next = T_IDLE;
            end
            default: state_next = T_IDLE;
        endcase
    end

    // Core handshake outputs; data is captured on entry to T_LOAD and held there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            uart_we      <= 1'b0;
            uart_data_in <= 8'h00;
        end else begin
            uart_we <= (state_next == T_LOAD);
            if ((state != T_LOAD) && (state_next == T_LOAD))
                uart_data_in <= tx_mem[tx_rptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= wdata;
        if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= uart_data_out;
    end

    // FIFO pointers; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else if (flush) begin
            tx_wptr <= '0;
            tx_rptr <= '0;
            rx_wptr <= '0;
            rx_rptr <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + PW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
            if (rx_push) rx_wptr <= rx_wptr + PW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_en <= 1'b0;
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
        end else begin
            if (wr_ctrl) {tx_ie, rx_ie, ctrl_en} <= wdata[2:0];
            if (tx_drop)                      tx_ovf <= 1'b1;
            else if (wr_status && wdata[5])   tx_ovf <= 1'b0;
            if (rx_drop)                      rx_ovf <= 1'b1;
            else if (wr_status && wdata[4])   rx_ovf <= 1'b0;
        end
    end

    // Registered read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 8'h00;
        end else if (rd) begin
            case (addr)
                A_DATA:   rdata <= rx_empty ? 8'h00 : rx_mem[rx_rptr[AW-1:0]];
                A_STATUS: rdata <= status_c;
                A_CTRL:   rdata <= {5'b0, tx_ie, rx_ie, ctrl_en};
                default:  rdata <= 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a small behavioural model of the core's
// transmit handshake (we sampled after a delay, tx_busy held for a frame).
module tb_uart_ctrl;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;
    localparam int LOAD_DLY = 3;
    localparam int BUSY_CYC = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       irq;
    logic       uart_en;
    logic       uart_we;
    logic [7:0] uart_data_in;
    logic       uart_tx_busy = 1'b0;
    logic       uart_rx_done = 1'b0;
    logic [7:0] uart_data_out = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] sent_q[$];
    int ld_cnt = 0;
    int busy_cnt = 0;
    int viol = 0;

    uart_ctrl #(.FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .wdata(wdata),
        .rdata(rdata), .irq(irq), .uart_en(uart_en), .uart_we(uart_we),
        .uart_data_in(uart_data_in), .uart_tx_busy(uart_tx_busy),
        .uart_rx_done(uart_rx_done), .uart_data_out(uart_data_out)
    );

    always #5 clk = ~clk;

    // Core TX model: accepts we after LOAD_DLY cycles, then stays busy for a frame
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            uart_tx_busy = 1'b0;
            ld_cnt       = 0;
            busy_cnt     = 0;
        end else if (uart_tx_busy) begin
            if (uart_we) viol++;
            if (busy_cnt == 0) uart_tx_busy = 1'b0;
            else busy_cnt--;
        end else if (uart_we) begin
            ld_cnt++;
            if (ld_cnt == LOAD_DLY) begin
                uart_tx_busy = 1'b1;
                busy_cnt     = BUSY_CYC - 1;
                ld_cnt       = 0;
                sent_q.push_back(uart_data_in);
            end
        end else begin
            ld_cnt = 0;
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
        addr = a; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        uart_data_out = d; uart_rx_done = 1'b1;
        @(posedge clk); #1;
        uart_rx_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus_wr(A_CTRL, 8'h01);
        bus_wr(A_DATA, 8'h5A);
        @(posedge clk); #1;
        checks++;
        if (uart_we !== 1'b1) begin
            errors++; $display("FAIL reset_pre_we got %0b want 1", uart_we);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({rdata, irq, uart_en, uart_we, uart_data_in} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdata=%h irq=%b en=%b we=%b din=%h want all 0",
                     rdata, irq, uart_en, uart_we, uart_data_in);
        end
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL reset_status got %h want 05", d); end
        bus_rd(A_CTRL, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %h want 00", d); end
        sent_q.delete();
        viol = 0;
    endtask

    task automatic test_tx_single();
        logic [7:0] d;
        int bad = 0;
        int n = 0;
        bus_wr(A_CTRL, 8'h01);
        bus_wr(A_DATA, 8'hA5);
        @(posedge clk); #1;
        while (!uart_tx_busy && n < 20) begin
            if (uart_we !== 1'b1 || uart_data_in !== 8'hA5) bad++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (bad != 0 || n < 2 || !uart_tx_busy) begin
            errors++;
            $display("FAIL tx_single_load bad=%0d cycles=%0d busy=%b want 0 bad, >=2 cycles, busy", bad, n, uart_tx_busy);
        end
        checks++;
        if (uart_we !== 1'b0) begin errors++; $display("FAIL tx_single_we_drop got %b want 0", uart_we); end
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h45) begin errors++; $display("FAIL tx_single_status got %h want 45", d); end
        n = 0;
        while (uart_tx_busy && n < 100) begin @(posedge clk); #1; n++; end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (viol != 0 || uart_we !== 1'b0 || sent_q.size() != 1) begin
            errors++;
            $display("FAIL tx_single_done viol=%0d we=%b sent=%0d want 0 0 1", viol, uart_we, sent_q.size());
        end else begin
            checks++;
            if (sent_q[0] !== 8'hA5) begin errors++; $display("FAIL tx_single_byte got %h want a5", sent_q[0]); end
        end
    endtask

    task automatic test_tx_burst();
        logic [7:0] d;
        int bad = 0;
        int n = 0;
        bus_wr(A_CTRL, 8'h00);
        for (int i = 0; i <= 16; i++) bus_wr(A_DATA, 8'(i));
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h29) begin errors++; $display("FAIL burst_full_status got %h want 29", d); end
        sent_q.delete();
        viol = 0;
        bus_wr(A_CTRL, 8'h01);
        while (!(sent_q.size() >= 16 && !uart_tx_busy) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sent_q.size() != 16 || viol != 0) begin
            errors++;
            $display("FAIL burst_count got %0d bytes viol=%0d want 16 bytes viol=0", sent_q.size(), viol);
        end else begin
            for (int i = 0; i < 16; i++) if (sent_q[i] !== 8'(i)) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL burst_order got %0d wrong bytes want 0", bad); end
        end
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h25) begin errors++; $display("FAIL burst_done_status got %h want 25", d); end
        bus_wr(A_STATUS, 8'h20);
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL burst_ovf_clear got %h want 05", d); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] d;
        int bad = 0;
        for (int i = 0; i < 16; i++) rx_pulse(8'h30 + 8'(i));
        rx_pulse(8'hFF);
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h16) begin errors++; $display("FAIL rx_ovf_status got %h want 16", d); end
        for (int i = 0; i < 16; i++) begin
            bus_rd(A_DATA, d);
            if (d !== 8'h30 + 8'(i)) begin
                bad++; $display("FAIL rx_read_%0d got %h want %h", i, d, 8'h30 + 8'(i));
            end
        end
        checks++;
        if (bad != 0) errors++;
        bus_rd(A_DATA, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rx_empty_read got %h want 00", d); end
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h15) begin errors++; $display("FAIL rx_empty_status got %h want 15", d); end
        bus_wr(A_STATUS, 8'h10);
    endtask

    task automatic test_simultaneous();
        logic [7:0] d;
        logic [7:0] exp;
        int bad = 0;
        for (int i = 0; i < 16; i++) rx_pulse(8'h40 + 8'(i));
        addr = A_DATA; rd = 1'b1;
        uart_data_out = 8'h55; uart_rx_done = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0; uart_rx_done = 1'b0;
        checks++;
        if (rdata !== 8'h40) begin errors++; $display("FAIL simul_pop got %h want 40", rdata); end
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL simul_status got %h want 06", d); end
        for (int i = 0; i < 16; i++) begin
            exp = (i == 15) ? 8'h55 : 8'h41 + 8'(i);
            bus_rd(A_DATA, d);
            if (d !== exp) begin bad++; $display("FAIL simul_read_%0d got %h want %h", i, d, exp); end
        end
        checks++;
        if (bad != 0) errors++;
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL simul_drained got %h want 05", d); end
    endtask

    task automatic test_irq_flush();
        logic [7:0] d;
        bus_wr(A_CTRL, 8'h07);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_tx_empty got %b want 1", irq); end
        bus_wr(A_CTRL, 8'h06);
        bus_wr(A_DATA, 8'h77);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_tx_pending got %b want 0", irq); end
        rx_pulse(8'h99);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_rx got %b want 1", irq); end
        bus_wr(A_CTRL, 8'h0E);
        bus_rd(A_STATUS, d);
        checks++;
        if (d !== 8'h05) begin errors++; $display("FAIL flush_status got %h want 05", d); end
        bus_rd(A_CTRL, d);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL flush_ctrl got %h want 06", d); end
    endtask

    task automatic test_reserved();
        logic [7:0] d;
        bus_wr(A_RSVD, 8'hFF);
        bus_rd(A_RSVD, d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL rsvd_read got %h want 00", d); end
        bus_rd(A_CTRL, d);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL rsvd_ctrl_untouched got %h want 06", d); end
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_burst();
        test_rx_overflow();
        test_simultaneous();
        test_irq_flush();
        test_reserved();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
